// File: rtl/mem_byte_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_byte_sequencer
// Description : Arbitrates a single-ported, byte-wide data RAM between an
//               instruction-fetch requester (word reads) and a load/store
//               requester (byte/half/word, read or write). Transfers one byte
//               per cycle, big-endian, and assembles reads into 32 bits with
//               zero- or sign-extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_byte_sequencer #(
    parameter int AW      = 9,
    parameter int D_FIRST = 1
) (
    input  logic          clk,
    input  logic          reset,
    // fetch requester
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic [31:0]   f_rdata,
    output logic          f_ack,
    // load/store requester
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [1:0]    d_size,
    input  logic          d_sext,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ack,
    // RAM side
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_d_q, owner_d_d;     // 1: load/store owns the access
    logic          rw_q, rw_d;
    logic [1:0]    size_q, size_d;
    logic          sext_q, sext_d;
    logic [AW-1:0] base_q, base_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    last_q, last_d;           // index of final byte (k-1)
    logic [23:0]   asm_q, asm_d;             // bytes collected so far
    logic          fair_q, fair_d;
    logic          lastwin_d_q, lastwin_d_d; // winner of last contested grant
    logic          f_ack_q, f_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [31:0]   f_rdata_q, f_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic          w_contested;
    logic          w_pick_d;
    logic          w_grant_d;
    logic [31:0]   w_asm_shift;
    logic [31:0]   w_ext;
    logic [1:0]    w_sel;

    // Arbitration: fairness flips the static priority after a contested grant
    assign w_contested = f_req & d_req;
    assign w_pick_d    = fair_q ? ~lastwin_d_q : (D_FIRST != 0);
    assign w_grant_d   = d_req & (~f_req | w_pick_d);

    // Read assembly and extension of the completed value
    assign w_asm_shift = {asm_q, mem_rdata};
    always_comb begin
        w_ext = w_asm_shift;
        if (rw_q) begin
            w_ext = 32'h0;
        end else begin
            case (size_q)
                2'b00:   w_ext = {{24{sext_q & w_asm_shift[7]}},  w_asm_shift[7:0]};
                2'b01:   w_ext = {{16{sext_q & w_asm_shift[15]}}, w_asm_shift[15:0]};
                default: w_ext = w_asm_shift;
            endcase
        end
    end

    // RAM interface driven purely from registered state
    assign w_sel     = last_q - idx_q;
    assign mem_en    = (state_q == S_XFER);
    assign mem_we    = (state_q == S_XFER) & rw_q;
    assign mem_addr  = base_q + {{(AW-2){1'b0}}, idx_q};
    assign mem_wdata = mem_we ? wdata_q[{w_sel, 3'b000} +: 8] : 8'h00;

    assign f_ack   = f_ack_q;
    assign d_ack   = d_ack_q;
    assign f_rdata = f_rdata_q;
    assign d_rdata = d_rdata_q;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_d_q   <= 1'b0;
            rw_q        <= 1'b0;
            size_q      <= 2'b00;
            sext_q      <= 1'b0;
            base_q      <= '0;
            wdata_q     <= 32'h0;
            idx_q       <= 2'd0;
            last_q      <= 2'd0;
            asm_q       <= 24'h0;
            fair_q      <= 1'b0;
            lastwin_d_q <= 1'b0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            f_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_d_q   <= owner_d_d;
            rw_q        <= rw_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            asm_q       <= asm_d;
            fair_q      <= fair_d;
            lastwin_d_q <= lastwin_d_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Next-state logic: grant in IDLE, stream bytes in XFER, ack in DONE
    always_comb begin
        state_d     = state_q;
        owner_d_d   = owner_d_q;
        rw_d        = rw_q;
        size_d      = size_q;
        sext_d      = sext_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        last_d      = last_q;
        asm_d       = asm_q;
        fair_d      = fair_q;
        lastwin_d_d = lastwin_d_q;
        f_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (f_req | d_req) begin
                    owner_d_d = w_grant_d;
                    if (w_grant_d) begin
                        rw_d    = d_rw;
                        size_d  = d_size;
                        sext_d  = d_sext;
                        base_d  = d_addr;
                        wdata_d = d_wdata;
                        last_d  = d_size[1] ? 2'd3 : (d_size[0] ? 2'd1 : 2'd0);
                    end else begin
                        rw_d    = 1'b0;
                        size_d  = 2'b10;
                        sext_d  = 1'b0;
                        base_d  = f_addr;
                        wdata_d = 32'h0;
                        last_d  = 2'd3;
                    end
                    idx_d  = 2'd0;
                    asm_d  = 24'h0;
                    fair_d = w_contested;
                    if (w_contested) begin
                        lastwin_d_d = w_grant_d;
                    end
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (!rw_q) begin
                    asm_d = w_asm_shift[23:0];
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == last_q) begin
                    state_d = S_DONE;
                    if (owner_d_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = w_ext;
                    end else begin
                        f_ack_d   = 1'b1;
                        f_rdata_d = w_asm_shift;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
